stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Data-stack sequencer for the 3-bit Forth core. It drives the load strobes and next values of the T (top) and N (second) stack registers, and manages the spill/fill stack RAM below them.
- It accepts one stack opcode per handshake, tracks stack depth, and flags overflow and underflow.
- It sits between the instruction decoder and the T/N registers plus the stack RAM.

Parameters:
- DW, 3, data width of T, N and the RAM words.
- MEM_DEPTH, 8, number of spill RAM entries.
- AW, 3, RAM address width; MEM_DEPTH must equal 2**AW.

Ports:
- clk  in  1  clock; all controller state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- op_valid  in  1  opcode offered.
- op_ready  out  1  controller can accept an opcode this cycle.
- op  in  3  0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 NIP, 7 CLR.
- lit  in  DW  literal for PUSH.
- t_q  in  DW  current T register value.
- n_q  in  DW  current N register value.
- t_in  out  DW  next T value.
- t_f  out  1  T load strobe.
- n_in  out  DW  next N value.
- n_f  out  1  N load strobe.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; synchronous read, valid one cycle after mem_addr.
- depth  out  AW+2  number of valid stack entries, range 0..MEM_DEPTH+2.
- ovf  out  1  overflow flag.
- unf  out  1  underflow flag.

Behaviour:
- Timing: t_in/t_f/n_in/n_f are registered and asserted for exactly one cycle. The T/N registers capture them on the following falling edge.
- Reset (rst_n low at a rising edge): state IDLE, sp=0, depth=0, all strobes 0, mem_we=0, ovf=0, unf=0, op_ready=1. Reset mid-op aborts the op with no further strobes.
- Handshake: an op is accepted when op_valid && op_ready. op_ready=1 only in IDLE. op is ignored while op_ready=0.
- FSM states: IDLE, FETCH, FILL.
- PUSH (1 cycle): mem[sp]<=n_q if depth>=2, n_in=t_q, t_in=lit, depth+1.
- DUP (1 cycle): same as PUSH but t unchanged (t_f=0). Requires depth>=1.
- OVER (1 cycle): spill n_q, n_in=t_q, t_in=n_q, depth+1. Requires depth>=2.
- SWAP (1 cycle): t_in=n_q, n_in=t_q. Requires depth>=2.
- DROP: t_in=n_q, depth-1.
  - If depth>2: go IDLE->FETCH (mem_addr=sp-1) ->FILL (n_in=mem_rdata, n_f=1, sp-1) ->IDLE.
  - Otherwise single cycle.
  - Requires depth>=1.
- NIP: same as DROP without the T load. Requires depth>=2.
- CLR (1 cycle): sp=0, depth=0, no strobes, flags unchanged.
- NOP: no effect.
- Spill rule: a RAM write occurs, and sp increments, only when pre-op depth>=2.
- Overflow: a depth-increasing op with depth==MEM_DEPTH+2 is not executed; ovf=1.
- Underflow: an op whose depth requirement is unmet is not executed; unf=1.
- Erroring ops still complete the handshake in 1 cycle.
- sp never wraps; the guards above make wrap impossible.
- Throughput: 1 op/cycle except DROP/NIP with fill, which take 3 cycles (op_ready low for 2 cycles).

Optional Feature:
- Macro: STACK_ERR_TRAP_EN.
- Defined:
  - ovf/unf are sticky.
  - While either flag is set, op_ready=0 except for CLR.
  - An accepted CLR clears both flags.
- Undefined:
  - ovf/unf are one-cycle pulses in the cycle after the offending op.
  - Operation continues normally.

Decomposition:
- Package stack_pkg:
  - opcode enum (OP_NOP..OP_CLR);
  - FSM state enum;
  - localparams DW and MEM_DEPTH defaults;
  - depth-requirement constants per opcode.
- One natural sub-module, stack_depth_chk: combinational; given op and depth, returns exec, ovf_hit, unf_hit.

Test Plan:
- Reset then PUSH 5, PUSH 3 -> cycle after each: t_f=1, t_in=5 then 3; second push n_in=5; depth=2; mem_we=0 on both.
- PUSH 1,2,3 -> third push mem_we=1, mem_addr=0, mem_wdata=1; then DROP -> op_ready low 2 cycles, FILL n_in=1, depth=2, sp=0.
- depth=2 (T=3, N=2): SWAP -> t_in=2, n_in=3; OVER -> t_in=3, mem_wdata=3; depth=3.
- Fill to depth=10, then PUSH 7 -> no strobes, ovf set, depth stays 10. With STACK_ERR_TRAP_EN: op_ready=0 until CLR, after which depth=0 and ovf=0.
- depth=0, then DROP -> unf set, no strobes; SWAP at depth=1 -> unf set.
- Assert rst_n=0 during FETCH of a DROP -> no FILL strobe, depth=0, IDLE next cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the data-stack sequencer.
package stack_pkg;

    localparam int DW_DEFAULT        = 3;
    localparam int MEM_DEPTH_DEFAULT = 8;
    localparam int AW_DEFAULT        = 3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_DROP = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_NIP  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // Minimum stack depth each opcode needs before it may execute.
    localparam logic [1:0] REQ_NOP  = 2'd0;
    localparam logic [1:0] REQ_PUSH = 2'd0;
    localparam logic [1:0] REQ_DROP = 2'd1;
    localparam logic [1:0] REQ_DUP  = 2'd1;
    localparam logic [1:0] REQ_SWAP = 2'd2;
    localparam logic [1:0] REQ_OVER = 2'd2;
    localparam logic [1:0] REQ_NIP  = 2'd2;
    localparam logic [1:0] REQ_CLR  = 2'd0;

    function automatic logic [1:0] op_req_depth(input op_e op);
        logic [1:0] req;
        req = REQ_NOP;
        case (op)
            OP_PUSH: req = REQ_PUSH;
            OP_DROP: req = REQ_DROP;
            OP_DUP:  req = REQ_DUP;
            OP_SWAP: req = REQ_SWAP;
            OP_OVER: req = REQ_OVER;
            OP_NIP:  req = REQ_NIP;
            OP_CLR:  req = REQ_CLR;
            default: req = REQ_NOP;
        endcase
        return req;
    endfunction

    function automatic logic op_grows(input op_e op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_depth_chk.sv
// Combinational depth guard: decides whether an opcode may execute at the current depth.
module stack_depth_chk
    import stack_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic [2:0]    op_i,
    input  logic [AW+1:0] depth_i,
    output logic          exec_o,
    output logic          ovf_hit_o,
    output logic          unf_hit_o
);

    localparam logic [AW+1:0] DEPTH_FULL = (AW+2)'(MEM_DEPTH + 2);

    op_e        op_w;
    logic [1:0] req_w;

    always_comb begin
        op_w      = op_e'(op_i);
        req_w     = op_req_depth(op_w);
        unf_hit_o = depth_i < (AW+2)'(req_w);
        ovf_hit_o = !unf_hit_o && op_grows(op_w) && (depth_i == DEPTH_FULL);
        exec_o    = !unf_hit_o && !ovf_hit_o;
    end

endmodule

// File: rtl/stack_seq.sv
// Data-stack sequencer: drives T/N load strobes and the spill/fill RAM below them.
// Build option STACK_ERR_TRAP_EN makes ovf/unf sticky and blocks all ops but CLR while set.
module stack_seq
    import stack_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int AW        = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] lit,
    input  logic [DW-1:0] t_q,
    input  logic [DW-1:0] n_q,
    output logic [DW-1:0] t_in,
    output logic          t_f,
    output logic [DW-1:0] n_in,
    output logic          n_f,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW+1:0] depth,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW+1:0] DEPTH_TWO = (AW+2)'(2);

    state_e        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [AW+1:0] depth_q, depth_d;
    logic [DW-1:0] t_in_q, t_in_d;
    logic          t_f_q, t_f_d;
    logic [DW-1:0] n_in_q, n_in_d;
    logic          n_f_q, n_f_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    op_e           op_w;
    logic          accept_w;
    logic          exec_w, ovf_hit_w, unf_hit_w;
    logic [AW:0]   sp_dec_w;

    stack_depth_chk #(
        .AW        (AW),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_depth_chk (
        .op_i      (op),
        .depth_i   (depth_q),
        .exec_o    (exec_w),
        .ovf_hit_o (ovf_hit_w),
        .unf_hit_o (unf_hit_w)
    );

    always_comb begin
        op_w = op_e'(op);
`ifdef STACK_ERR_TRAP_EN
        op_ready = (state_q == ST_IDLE) && (!(ovf_q || unf_q) || (op_w == OP_CLR));
`else
        op_ready = (state_q == ST_IDLE);
`endif
        accept_w = op_valid && op_ready;
        sp_dec_w = sp_q - (AW+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        t_in_d      = t_in_q;
        t_f_d       = 1'b0;
        n_in_d      = n_in_q;
        n_f_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
`ifdef STACK_ERR_TRAP_EN
        ovf_d       = ovf_q;
        unf_d       = unf_q;
`else
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    ovf_d = ovf_d | ovf_hit_w;
                    unf_d = unf_d | unf_hit_w;
                    if (exec_w) begin
                        case (op_w)
                            OP_PUSH, OP_DUP, OP_OVER: begin
                                // N spills to RAM only once both T and N hold live entries.
                                if (depth_q >= DEPTH_TWO) begin
                                    mem_we_d    = 1'b1;
                                    mem_addr_d  = sp_q[AW-1:0];
                                    mem_wdata_d = n_q;
                                    sp_d        = sp_q + (AW+1)'(1);
                                end
                                n_in_d  = t_q;
                                n_f_d   = 1'b1;
                                depth_d = depth_q + (AW+2)'(1);
                                if (op_w == OP_PUSH) begin
                                    t_in_d = lit;
                                    t_f_d  = 1'b1;
                                end else if (op_w == OP_OVER) begin
                                    t_in_d = n_q;
                                    t_f_d  = 1'b1;
                                end
                            end
                            OP_SWAP: begin
                                t_in_d = n_q;
                                t_f_d  = 1'b1;
                                n_in_d = t_q;
                                n_f_d  = 1'b1;
                            end
                            OP_DROP, OP_NIP: begin
                                if (op_w == OP_DROP) begin
                                    t_in_d = n_q;
                                    t_f_d  = 1'b1;
                                end
                                depth_d = depth_q - (AW+2)'(1);
                                // RAM holds entries below N: refill N from the top of RAM.
                                if (depth_q > DEPTH_TWO) begin
                                    mem_addr_d = sp_dec_w[AW-1:0];
                                    state_d    = ST_FETCH;
                                end
                            end
                            OP_CLR: begin
                                sp_d    = '0;
                                depth_d = '0;
`ifdef STACK_ERR_TRAP_EN
                                ovf_d   = 1'b0;
                                unf_d   = 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                n_in_d  = mem_rdata;
                n_f_d   = 1'b1;
                sp_d    = sp_dec_w;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sp_q        <= '0;
            depth_q     <= '0;
            t_in_q      <= '0;
            t_f_q       <= 1'b0;
            n_in_q      <= '0;
            n_f_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            t_in_q      <= t_in_d;
            t_f_q       <= t_f_d;
            n_in_q      <= n_in_d;
            n_f_q       <= n_f_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign t_in      = t_in_q;
    assign t_f       = t_f_q;
    assign n_in      = n_in_q;
    assign n_f       = n_f_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign depth     = depth_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with T/N registers (falling-edge capture) and a sync-read RAM.
module tb_stack_seq;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [2:0] lit = 3'd0;
    logic [2:0] t_q = 3'd0;
    logic [2:0] n_q = 3'd0;
    logic [2:0] mem_rdata = 3'd0;
    logic       op_ready, t_f, n_f, mem_we, ovf, unf;
    logic [2:0] t_in, n_in, mem_wdata, mem_addr;
    logic [4:0] depth;
    logic [2:0] ram [8];

    int checks = 0;
    int errors = 0;

    stack_seq #(
        .DW        (3),
        .MEM_DEPTH (8),
        .AW        (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .lit       (lit),
        .t_q       (t_q),
        .n_q       (n_q),
        .t_in      (t_in),
        .t_f       (t_f),
        .n_in      (n_in),
        .n_f       (n_f),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (t_f) t_q <= t_in;
        if (n_f) n_q <= n_in;
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic do_reset();
        rst_n = 1'b0; op_valid = 1'b0; op = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one op for one edge; outputs of that op are visible on return.
    task automatic issue(input logic [2:0] o, input logic [2:0] l);
        op_valid = 1'b1; op = o; lit = l;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0d exp 1", op_ready); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL rst_depth got %0d exp 0", depth); end
        checks++; if ({t_f, n_f, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {t_f, n_f, mem_we}); end
        checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {ovf, unf}); end
    endtask

    task automatic test_push();
        do_reset();
        issue(OP_PUSH, 3'd5);
        checks++; if ({t_f, t_in} !== {1'b1, 3'd5}) begin errors++; $display("FAIL push1_t got f=%0d v=%0d exp f=1 v=5", t_f, t_in); end
        checks++; if ({n_f, mem_we} !== 2'b10) begin errors++; $display("FAIL push1_nf_we got %b exp 10", {n_f, mem_we}); end
        issue(OP_PUSH, 3'd3);
        checks++; if ({t_f, t_in} !== {1'b1, 3'd3}) begin errors++; $display("FAIL push2_t got f=%0d v=%0d exp f=1 v=3", t_f, t_in); end
        checks++; if ({n_f, n_in} !== {1'b1, 3'd5}) begin errors++; $display("FAIL push2_n got f=%0d v=%0d exp f=1 v=5", n_f, n_in); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL push2_we got %0d exp 0", mem_we); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL push2_depth got %0d exp 2", depth); end
    endtask

    task automatic test_spill_fill();
        do_reset();
        issue(OP_PUSH, 3'd1);
        issue(OP_PUSH, 3'd2);
        issue(OP_PUSH, 3'd3);
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 3'd0, 3'd1}) begin errors++; $display("FAIL spill got we=%0d a=%0d d=%0d exp we=1 a=0 d=1", mem_we, mem_addr, mem_wdata); end
        checks++; if (depth !== 5'd3) begin errors++; $display("FAIL spill_depth got %0d exp 3", depth); end
        issue(OP_DROP, 3'd0);
        checks++; if ({t_f, t_in, n_f} !== {1'b1, 3'd2, 1'b0}) begin errors++; $display("FAIL drop_t got tf=%0d t=%0d nf=%0d exp tf=1 t=2 nf=0", t_f, t_in, n_f); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL drop_fetch_ready got %0d exp 0", op_ready); end
        @(posedge clk); #1;
        checks++; if ({op_ready, n_f} !== 2'b00) begin errors++; $display("FAIL drop_fill_ready got %b exp 00", {op_ready, n_f}); end
        @(posedge clk); #1;
        checks++; if ({op_ready, n_f, n_in} !== {1'b1, 1'b1, 3'd1}) begin errors++; $display("FAIL fill_n got rdy=%0d nf=%0d n=%0d exp rdy=1 nf=1 n=1", op_ready, n_f, n_in); end
        checks++; if (depth !== 5'd2) begin errors++; $display("FAIL fill_depth got %0d exp 2", depth); end
        // sp back to 0: next spill lands at address 0 with N=1, T=2.
        issue(OP_PUSH, 3'd4);
        checks++; if ({mem_we, mem_addr, mem_wdata, n_in} !== {1'b1, 3'd0, 3'd1, 3'd2}) begin errors++; $display("FAIL refill_push got we=%0d a=%0d d=%0d n=%0d exp we=1 a=0 d=1 n=2", mem_we, mem_addr, mem_wdata, n_in); end
    endtask

    task automatic test_swap_over();
        do_reset();
        issue(OP_PUSH, 3'd2);
        issue(OP_PUSH, 3'd3);
        issue(OP_SWAP, 3'd0);
        checks++; if ({t_f, t_in, n_f, n_in} !== {1'b1, 3'd2, 1'b1, 3'd3}) begin errors++; $display("FAIL swap got t=%0d n=%0d exp t=2 n=3", t_in, n_in); end
        checks++; if ({mem_we, depth} !== {1'b0, 5'd2}) begin errors++; $display("FAIL swap_depth got we=%0d d=%0d exp we=0 d=2", mem_we, depth); end
        issue(OP_OVER, 3'd0);
        checks++; if ({t_f, t_in, n_in} !== {1'b1, 3'd3, 3'd2}) begin errors++; $display("FAIL over_tn got t=%0d n=%0d exp t=3 n=2", t_in, n_in); end
        checks++; if ({mem_we, mem_addr, mem_wdata, depth} !== {1'b1, 3'd0, 3'd3, 5'd3}) begin errors++; $display("FAIL over_spill got we=%0d a=%0d d=%0d dep=%0d exp we=1 a=0 d=3 dep=3", mem_we, mem_addr, mem_wdata, depth); end
        issue(OP_DUP, 3'd0);
        checks++; if ({t_f, n_f, n_in} !== {1'b0, 1'b1, 3'd3}) begin errors++; $display("FAIL dup got tf=%0d nf=%0d n=%0d exp tf=0 nf=1 n=3", t_f, n_f, n_in); end
        checks++; if ({mem_we, mem_addr, mem_wdata, depth} !== {1'b1, 3'd1, 3'd2, 5'd4}) begin errors++; $display("FAIL dup_spill got we=%0d a=%0d d=%0d dep=%0d exp we=1 a=1 d=2 dep=4", mem_we, mem_addr, mem_wdata, depth); end
        issue(OP_NIP, 3'd0);
        checks++; if ({t_f, op_ready, depth} !== {1'b0, 1'b0, 5'd3}) begin errors++; $display("FAIL nip got tf=%0d rdy=%0d dep=%0d exp tf=0 rdy=0 dep=3", t_f, op_ready, depth); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({n_f, n_in, op_ready} !== {1'b1, 3'd2, 1'b1}) begin errors++; $display("FAIL nip_fill got nf=%0d n=%0d rdy=%0d exp nf=1 n=2 rdy=1", n_f, n_in, op_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) issue(OP_PUSH, 3'(i));
        checks++; if ({depth, mem_addr, mem_wdata} !== {5'd10, 3'd7, 3'd7}) begin errors++; $display("FAIL fill10 got dep=%0d a=%0d d=%0d exp dep=10 a=7 d=7", depth, mem_addr, mem_wdata); end
        issue(OP_PUSH, 3'd7);
        checks++; if ({t_f, n_f, mem_we} !== 3'b000) begin errors++; $display("FAIL ovf_strobes got %b exp 000", {t_f, n_f, mem_we}); end
        checks++; if ({ovf, unf, depth} !== {1'b1, 1'b0, 5'd10}) begin errors++; $display("FAIL ovf_flag got ovf=%0d unf=%0d dep=%0d exp ovf=1 unf=0 dep=10", ovf, unf, depth); end
`ifdef STACK_ERR_TRAP_EN
        op = OP_PUSH; #1;
        checks++; if ({op_ready, ovf} !== 2'b01) begin errors++; $display("FAIL trap_block got rdy=%0d ovf=%0d exp rdy=0 ovf=1", op_ready, ovf); end
        op = OP_CLR; #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL trap_clr_ready got %0d exp 1", op_ready); end
`else
        @(posedge clk); #1;
        checks++; if ({ovf, op_ready} !== 2'b01) begin errors++; $display("FAIL ovf_pulse got ovf=%0d rdy=%0d exp ovf=0 rdy=1", ovf, op_ready); end
`endif
        issue(OP_CLR, 3'd0);
        checks++; if ({depth, ovf, t_f, n_f} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL clr got dep=%0d ovf=%0d exp dep=0 ovf=0", depth, ovf); end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(OP_DROP, 3'd0);
        checks++; if ({unf, t_f, n_f, depth, op_ready} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin errors++; $display("FAIL unf_drop got unf=%0d tf=%0d nf=%0d dep=%0d exp unf=1 tf=0 nf=0 dep=0", unf, t_f, n_f, depth); end
        issue(OP_CLR, 3'd0);
        checks++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %0d exp 0", unf); end
        issue(OP_PUSH, 3'd1);
        issue(OP_SWAP, 3'd0);
        checks++; if ({unf, t_f, n_f, depth} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin errors++; $display("FAIL unf_swap got unf=%0d tf=%0d nf=%0d dep=%0d exp unf=1 0 0 dep=1", unf, t_f, n_f, depth); end
        issue(OP_CLR, 3'd0);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        issue(OP_PUSH, 3'd1);
        issue(OP_PUSH, 3'd2);
        issue(OP_PUSH, 3'd3);
        issue(OP_DROP, 3'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if ({depth, n_f, t_f, op_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL midrst got dep=%0d nf=%0d tf=%0d rdy=%0d exp 0 0 0 1", depth, n_f, t_f, op_ready); end
        @(posedge clk); #1;
        checks++; if ({n_f, mem_we, depth} !== {1'b0, 1'b0, 5'd0}) begin errors++; $display("FAIL midrst_nofill got nf=%0d we=%0d dep=%0d exp 0 0 0", n_f, mem_we, depth); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 3'd0;
        test_reset();
        test_push();
        test_spill_fill();
        test_swap_over();
        test_overflow();
        test_underflow();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
